// File: rtl/mux_arbiter_if.sv
// Handshake bundle for mux_arbiter: NUM_IN packed source channels in, one registered word out.
// The master drives the sources and the sink ready; the slave is the arbiter.
interface mux_arbiter_if #(
    parameter int unsigned N      = 16,
    parameter int unsigned NUM_IN = 4
);
    localparam int unsigned SEL_W = $clog2(NUM_IN);

    logic [NUM_IN*N-1:0] in_data;
    logic [NUM_IN-1:0]   in_valid;
    logic [NUM_IN-1:0]   in_ready;
    logic [SEL_W-1:0]    sel;
    logic [N-1:0]        out_data;
    logic                out_valid;
    logic                out_ready;
    logic [SEL_W-1:0]    out_src;

    modport master (
        output in_data, in_valid, sel, out_ready,
        input  in_ready, out_data, out_valid, out_src
    );

    modport slave (
        input  in_data, in_valid, sel, out_ready,
        output in_ready, out_data, out_valid, out_src
    );
endinterface

// File: rtl/mux_arbiter.sv
// N-input registered word selector with valid/ready on every port.
// MODE: 0 = external sel, 1 = round-robin, 2 = fixed priority (lowest index wins).
module mux_arbiter #(
    parameter int unsigned N      = 16,
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned MODE   = 0
) (
    input logic          clk,
    input logic          rst,
    mux_arbiter_if.slave bus
);
    localparam int unsigned SEL_W = $clog2(NUM_IN);

    logic [N-1:0]      data_q, data_d;
    logic [SEL_W-1:0]  src_q, src_d;
    logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              valid_q, valid_d;

    logic              can_load;
    logic              win_found;
    logic [SEL_W-1:0]  win_idx;
    logic [N-1:0]      win_data;
    logic [NUM_IN-1:0] rr_rot;
    int unsigned       rr_c;

    assign can_load = !valid_q || bus.out_ready;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        rr_rot    = '0;
        rr_c      = 0;
        if (MODE == 0) begin
            // Out-of-range sel never matches a channel, so it selects nothing.
            for (int unsigned i = 0; i < NUM_IN; i++) begin
                if (bus.sel == SEL_W'(i) && bus.in_valid[i]) begin
                    win_found = 1'b1;
                    win_idx   = SEL_W'(i);
                end
            end
        end else if (MODE == 1) begin
            // Rotate so bit 0 is the channel just after the last winner.
            rr_rot = NUM_IN'({bus.in_valid, bus.in_valid} >> (32'(rr_ptr_q) + 1));
            for (int unsigned j = 0; j < NUM_IN; j++) begin
                if (!win_found && rr_rot[j]) begin
                    rr_c = 32'(rr_ptr_q) + 1 + j;
                    if (rr_c >= NUM_IN) begin
                        rr_c = rr_c - NUM_IN;
                    end
                    win_found = 1'b1;
                    win_idx   = SEL_W'(rr_c);
                end
            end
        end else begin
            for (int unsigned i = 0; i < NUM_IN; i++) begin
                if (!win_found && bus.in_valid[i]) begin
                    win_found = 1'b1;
                    win_idx   = SEL_W'(i);
                end
            end
        end
    end

    always_comb begin
        win_data     = '0;
        bus.in_ready = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (win_idx == SEL_W'(i)) begin
                win_data = bus.in_data[i*N +: N];
            end
            bus.in_ready[i] = can_load && win_found && (win_idx == SEL_W'(i));
        end
    end

    // A winner always has in_valid set, so a grant with can_load is a transfer.
    always_comb begin
        data_d   = data_q;
        src_d    = src_q;
        valid_d  = valid_q;
        rr_ptr_d = rr_ptr_q;
        if (can_load && win_found) begin
            data_d  = win_data;
            src_d   = win_idx;
            valid_d = 1'b1;
            if (MODE == 1) begin
                rr_ptr_d = win_idx;
            end
        end else if (bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q   <= '0;
            src_q    <= '0;
            valid_q  <= 1'b0;
            rr_ptr_q <= SEL_W'(NUM_IN - 1);
        end else begin
            data_q   <= data_d;
            src_q    <= src_d;
            valid_q  <= valid_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_src   = src_q;
    assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_mux_arbiter.sv
// Scoreboard bench for mux_arbiter: one instance per selection mode, NUM_IN=4, N=16.
// Expected words are queued at grant time and popped by a monitor on each output handshake.
module tb_mux_arbiter;
    logic        clk;
    logic        rst;
    logic [63:0] din;
    logic [3:0]  vld0, vld1, vld2;
    logic        rdy0, rdy1, rdy2;
    logic [1:0]  sel0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [17:0] q0[$];
    logic [17:0] q1[$];
    logic [17:0] q2[$];

    mux_arbiter_if #(.N(16), .NUM_IN(4)) if0 ();
    mux_arbiter_if #(.N(16), .NUM_IN(4)) if1 ();
    mux_arbiter_if #(.N(16), .NUM_IN(4)) if2 ();

    mux_arbiter #(.N(16), .NUM_IN(4), .MODE(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    mux_arbiter #(.N(16), .NUM_IN(4), .MODE(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    mux_arbiter #(.N(16), .NUM_IN(4), .MODE(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    assign if0.in_data   = din;
    assign if1.in_data   = din;
    assign if2.in_data   = din;
    assign if0.in_valid  = vld0;
    assign if1.in_valid  = vld1;
    assign if2.in_valid  = vld2;
    assign if0.out_ready = rdy0;
    assign if1.out_ready = rdy1;
    assign if2.out_ready = rdy2;
    assign if0.sel       = sel0;
    assign if1.sel       = 2'd0;
    assign if2.sel       = 2'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic to_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    // Check in_ready against the expected grant g (-1: none) and queue the word it should yield.
    task automatic exp_grant(input int k, input int g, input string name);
        logic [3:0]  act;
        logic [3:0]  req;
        logic [17:0] w;
        req = (g < 0) ? 4'b0000 : (4'b0001 << g);
        case (k)
            0:       act = if0.in_ready;
            1:       act = if1.in_ready;
            default: act = if2.in_ready;
        endcase
        chk(name, {28'd0, act}, {28'd0, req});
        if (g >= 0) begin
            w = {g[1:0], din[g*16 +: 16]};
            case (k)
                0:       q0.push_back(w);
                1:       q1.push_back(w);
                default: q2.push_back(w);
            endcase
        end
    endtask

    task automatic mon(input int k, input logic [1:0] src, input logic [15:0] data);
        int          sz;
        logic [17:0] w;
        case (k)
            0:       sz = q0.size();
            1:       sz = q1.size();
            default: sz = q2.size();
        endcase
        if (sz == 0) begin
            chk($sformatf("mon%0d_unexpected_word", k), sz, 1);
        end else begin
            case (k)
                0:       w = q0.pop_front();
                1:       w = q1.pop_front();
                default: w = q2.pop_front();
            endcase
            chk($sformatf("mon%0d_src_data", k), {14'd0, src, data}, {14'd0, w});
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (if0.out_valid && if0.out_ready) mon(0, if0.out_src, if0.out_data);
            if (if1.out_valid && if1.out_ready) mon(1, if1.out_src, if1.out_data);
            if (if2.out_valid && if2.out_ready) mon(2, if2.out_src, if2.out_data);
        end
    end

    initial begin
        int g;
        int c;
        logic       m_valid;
        logic [1:0] m_ptr;

        rst  = 1'b0;
        din  = {$urandom(), $urandom()};
        vld0 = 4'($urandom());
        vld1 = 4'($urandom());
        vld2 = 4'($urandom());
        sel0 = 2'($urandom());
        rdy0 = 1'b1;
        rdy1 = 1'b1;
        rdy2 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vld0 = '0;
        vld1 = '0;
        vld2 = '0;
        rst  = 1'b1;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            to_neg();
            chk("rst_out0", {if0.out_valid, if0.out_src, if0.out_data, if0.in_ready}, 32'd0);
            chk("rst_out1", {if1.out_valid, if1.out_src, if1.out_data, if1.in_ready}, 32'd0);
            chk("rst_out2", {if2.out_valid, if2.out_src, if2.out_data, if2.in_ready}, 32'd0);
            to_pos();
        end

        // External select
        din  = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
        vld0 = 4'hF;
        sel0 = 2'd2;
        to_neg(); exp_grant(0, 2, "m0_sel2"); to_pos();
        sel0 = 2'd3;
        vld0 = 4'b0111;
        to_neg(); exp_grant(0, -1, "m0_sel3_invalid"); to_pos();
        to_neg();
        chk("m0_drained", {if0.out_valid, if0.out_src, if0.out_data}, {13'd0, 1'b0, 2'd2, 16'hCCCC});
        exp_grant(0, -1, "m0_still_none");
        to_pos();
        sel0 = 2'd1;
        to_neg(); exp_grant(0, 1, "m0_sel1"); to_pos();
        vld0 = '0;
        to_neg(); exp_grant(0, -1, "m0_idle"); to_pos();

        // Round-robin fairness
        vld1 = 4'hF;
        for (int i = 0; i < 8; i++) begin
            to_neg(); exp_grant(1, i % 4, "rr_all"); to_pos();
        end
        vld1 = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            to_neg(); exp_grant(1, (i % 2 == 1) ? 3 : 1, "rr_ch13"); to_pos();
        end
        vld1 = '0;
        to_neg(); exp_grant(1, -1, "rr_idle"); to_pos();

        // Fixed priority
        vld2 = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            to_neg(); exp_grant(2, 1, "pri_1_over_2"); to_pos();
        end
        vld2 = 4'b0100;
        for (int i = 0; i < 2; i++) begin
            to_neg(); exp_grant(2, 2, "pri_2_alone"); to_pos();
        end
        vld2 = '0;
        to_neg(); exp_grant(2, -1, "pri_idle"); to_pos();

        // Backpressure on round-robin (pointer at 3 from the last grant)
        vld1 = 4'hF;
        rdy1 = 1'b0;
        to_neg(); exp_grant(1, 0, "bp_load"); to_pos();
        for (int i = 0; i < 5; i++) begin
            to_neg();
            exp_grant(1, -1, "bp_no_ready");
            chk("bp_hold", {if1.out_valid, if1.out_src, if1.out_data}, {13'd0, 1'b1, 2'd0, 16'hAAAA});
            to_pos();
        end
        rdy1 = 1'b1;
        to_neg(); exp_grant(1, 1, "bp_resume"); to_pos();
        to_neg(); exp_grant(1, 2, "bp_next"); to_pos();
        vld1 = '0;
        to_neg(); exp_grant(1, -1, "bp_idle"); to_pos();

        // Random valid/ready traffic against a reference round-robin model
        m_valid = 1'b0;
        m_ptr   = 2'd2;
        for (int i = 0; i < 200; i++) begin
            din  = {$urandom(), $urandom()};
            vld1 = 4'($urandom());
            rdy1 = ($urandom_range(3) != 0);
            to_neg();
            g = -1;
            if (!m_valid || rdy1) begin
                for (int j = 1; j <= 4; j++) begin
                    c = (int'(m_ptr) + j) % 4;
                    if (g < 0 && vld1[c]) g = c;
                end
            end
            exp_grant(1, g, "rand_grant");
            if (g >= 0) begin
                m_valid = 1'b1;
                m_ptr   = g[1:0];
            end else if (rdy1) begin
                m_valid = 1'b0;
            end
            to_pos();
        end
        vld1 = '0;
        rdy1 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            to_neg(); exp_grant(1, -1, "rand_drain"); to_pos();
        end
        chk("rand_all_delivered", q1.size(), 0);

        // Asynchronous reset while a word is held
        din  = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
        vld1 = 4'b0100;
        rdy1 = 1'b0;
        to_neg(); exp_grant(1, 2, "rst_load"); to_pos();
        #2;
        chk("rst_pre_held", {31'd0, if1.out_valid}, 32'd1);
        rst = 1'b0;
        #1;
        chk("rst_async_clear", {if1.out_valid, if1.out_src, if1.out_data}, 32'd0);
        q1.delete();
        vld1 = 4'hF;
        rdy1 = 1'b1;
        @(negedge clk);
        #1;
        rst = 1'b1;
        exp_grant(1, 0, "rst_rr_first");
        to_pos();
        vld1 = '0;
        to_neg(); exp_grant(1, -1, "rst_idle"); to_pos();
        to_neg();
        chk("rst_final_drain", {31'd0, if1.out_valid}, 32'd0);

        chk("q0_empty", q0.size(), 0);
        chk("q1_empty", q1.size(), 0);
        chk("q2_empty", q2.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mux_arbiter.md
Name: mux_arbiter

Overview:
Parametrised N-input, registered word selector with valid/ready handshakes on every input and on the output. It generalises the pipeline's combinational 2:1/4:1 data muxes to any channel count. It adds three selection modes: external select, round-robin, and fixed priority. One output register decouples the source side from the sink. Used wherever several pipeline producers share one consumer, for example forwarding or writeback sources.

Parameters:
- N, 16, data word width in bits.
- NUM_IN, 4, number of input channels; legal range 2..16.
- MODE, 0, selection mode: 0 = external sel, 1 = round-robin, 2 = fixed priority (lowest index wins).
- SEL_W, $clog2(NUM_IN), derived localparam; not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- in_data  input  NUM_IN*N  packed input words; channel i occupies bits [i*N +: N].
- in_valid  input  NUM_IN  per-channel valid.
- in_ready  output  NUM_IN  per-channel ready; combinational.
- sel  input  SEL_W  channel select; used only when MODE=0.
- out_data  output  N  registered selected word.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  sink accepts out_data this cycle.
- out_src  output  SEL_W  index of the channel that produced out_data.

Behaviour:
- Reset (rst=0, asynchronous): out_valid=0, out_data=0, out_src=0, rr_ptr=NUM_IN-1. After reset, round-robin therefore searches from channel 0 first. Asserting reset mid-transfer discards the held word.
- can_load = !out_valid || out_ready.
- Winner selection, combinational and evaluated every cycle:
  - MODE 0: winner = sel if sel < NUM_IN and in_valid[sel]=1; otherwise no winner. Valid words on other channels are ignored.
  - MODE 1: winner = first channel with in_valid=1, searching cyclically from rr_ptr+1 (mod NUM_IN) through rr_ptr.
  - MODE 2: winner = lowest index with in_valid=1.
- in_ready[i] = can_load && winner exists && winner==i. At most one bit is set; all bits are 0 when there is no winner. in_ready does not depend on in_valid of non-winning channels.
- Transfer at a rising edge where in_valid[w] && in_ready[w]:
  - out_data <= in_data[w]
  - out_src <= w
  - out_valid <= 1
  - MODE 1 only: rr_ptr <= w.
- Output drain: if out_valid && out_ready and no new transfer, out_valid <= 0. out_data and out_src hold their last values.
- Simultaneous drain and load (out_valid=1, out_ready=1, winner exists) in the same cycle: the new word replaces the old one. out_valid stays 1. No bubble; full throughput of 1 word/cycle.
- Backpressure (out_valid=1, out_ready=0): all in_ready=0. out_data, out_src, out_valid and rr_ptr hold.
- Latency: 1 cycle from input handshake to out_valid.
- rr_ptr changes only on a transfer. Idle cycles do not advance it.
- Source data is never duplicated or dropped: every input handshake yields exactly one output handshake unless reset intervenes.
- Non-power-of-2 NUM_IN: in MODE 0, sel values >= NUM_IN select nothing. rr_ptr wraps at NUM_IN-1 to 0.
- out_src width is SEL_W. With NUM_IN=2, SEL_W=1.

Test Plan:
- Reset/idle: rst=0 with random inputs, then release with all in_valid=0 -> out_valid=0, out_data=0, out_src=0, in_ready=0 for 10 cycles.
- MODE 0, NUM_IN=4, N=16: in_data={16'hDDDD,16'hCCCC,16'hBBBB,16'hAAAA}, all valid, sel=2, out_ready=1 -> in_ready=4'b0100; next cycle out_data=16'hCCCC, out_src=2. Then sel=3 with in_valid[3]=0 -> in_ready=0 and out_valid falls to 0.
- MODE 1 fairness: all 4 channels held valid, out_ready=1 for 8 cycles -> out_src sequence 0,1,2,3,0,1,2,3 with no idle cycles. Repeat with only channels 1 and 3 valid -> 1,3,1,3.
- MODE 2 priority: channels 1 and 2 valid -> channel 1 wins every cycle and channel 2 is never granted until in_valid[1] drops.
- Backpressure: MODE 1, out_ready=0 for 5 cycles after the first load -> in_ready=0, and out_data, out_src and rr_ptr are unchanged. On out_ready=1 the next grant goes to rr_ptr+1 and the stream continues without loss or duplication. Check with a scoreboard of 200 random valid/ready cycles.
- Reset mid-stream: assert rst asynchronously while out_valid=1 -> out_valid drops immediately. After release, MODE 1 grants channel 0 first.
